note_sequencer: RTL and testbench

- Queues note commands from the host-side control logic and plays them back in order on the frequency PWM generator.
- For each note: drives the period word and volume, issues a one-cycle new-period strobe, and holds the note for a programmed duration in milliseconds.
- Inserts a fixed muted gap between notes.
- Sits between the host register interface and the PWM generator. The top level gates the PWM output with `mute`.

---
 rtl/note_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_note_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// note_sequencer: note FIFO plus playback controller feeding the PWM tone generator.
// Each queued note {div, vol, dur_ms} is loaded, strobed into the generator, held
// for dur_ms milliseconds and followed by a fixed muted gap.
module note_sequencer #(
   parameter int DEPTH       = 8,
   parameter int CLKS_PER_MS = 100000,
   parameter int GAP_MS      = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   stop,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [31:0]            wr_div,
   input  logic [3:0]             wr_vol,
   input  logic [15:0]            wr_dur_ms,
   output logic [31:0]            clks_per_period,
   output logic [3:0]             volume,
   output logic                   new_period,
   output logic                   mute,
   output logic                   busy,
   output logic                   note_done,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
   localparam logic [PW-1:0] PRE_LAST   = PW'(CLKS_PER_MS - 1);
   localparam logic [15:0]   GAP_LAST   = 16'((GAP_MS > 0) ? GAP_MS - 1 : 0);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

   // note storage, packed as {div, vol, dur}
   logic [51:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;

   logic [51:0]   head;
   logic [31:0]   head_div;
   logic [3:0]    head_vol;
   logic [15:0]   head_dur;

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [15:0]   ms_q, ms_d;
   logic          rest_q, rest_d;
   logic [31:0]   cpp_q, cpp_d;
   logic [3:0]    vol_q, vol_d;
   logic          np_q, np_d;
   logic          mute_q, mute_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          last_tick;
   state_t        after_note;

   assign head     = mem_q[rd_ptr_q];
   assign head_div = head[51:20];
   assign head_vol = head[19:16];
   assign head_dur = head[15:0];

   // FIFO bookkeeping; stop flushes and overrides any push or pop in the same cycle
   always_comb begin
      push     = wr_valid && (count_q != FULL_COUNT) && !stop;
      pop      = (state_q == S_LOAD) && !stop;
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
      if (stop) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   // note RAM write port, no reset needed on the storage itself
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {wr_div, wr_vol, wr_dur_ms};
      end
   end

   // playback controller: next state, ms timing and next values of the registered outputs
   always_comb begin
      state_d    = state_q;
      pre_d      = pre_q;
      ms_d       = ms_q;
      rest_d     = rest_q;
      cpp_d      = cpp_q;
      vol_d      = vol_q;
      last_tick  = (pre_q == PRE_LAST) && (ms_q == 16'd0);
      after_note = (enable && (count_q != '0)) ? S_LOAD : S_IDLE;

      case (state_q)
         S_IDLE: begin
            if (enable && (count_q != '0)) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (head_dur == 16'd0) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_PLAY;
               pre_d   = '0;
               ms_d    = head_dur - 16'd1;
               rest_d  = (head_div == 32'd0);
               if (head_div != 32'd0) begin
                  cpp_d = head_div;
                  vol_d = head_vol;
               end
            end
         end
         S_PLAY, S_GAP: begin
            if (last_tick) begin
               if ((state_q == S_PLAY) && (GAP_MS > 0)) begin
                  state_d = S_GAP;
                  pre_d   = '0;
                  ms_d    = GAP_LAST;
               end else begin
                  state_d = after_note;
               end
            end else if (pre_q == PRE_LAST) begin
               pre_d = '0;
               ms_d  = ms_q - 16'd1;
            end else begin
               pre_d = pre_q + PW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (stop) state_d = S_IDLE;

      // outputs are computed from the state being entered so they line up with it
      np_d   = (state_q == S_LOAD) && (state_d == S_PLAY) && !rest_d;
      mute_d = !((state_d == S_PLAY) && !rest_d);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_PLAY) && (pre_d == PRE_LAST) && (ms_d == 16'd0);
   end

   // state, counters and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         pre_q    <= '0;
         ms_q     <= '0;
         rest_q   <= 1'b0;
         cpp_q    <= '0;
         vol_q    <= '0;
         np_q     <= 1'b0;
         mute_q   <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pre_q    <= pre_d;
         ms_q     <= ms_d;
         rest_q   <= rest_d;
         cpp_q    <= cpp_d;
         vol_q    <= vol_d;
         np_q     <= np_d;
         mute_q   <= mute_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign wr_ready        = (count_q != FULL_COUNT);
   assign fifo_count      = count_q;
   assign clks_per_period = cpp_q;
   assign volume          = vol_q;
   assign new_period      = np_q;
   assign mute            = mute_q;
   assign busy            = busy_q;
   assign note_done       = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed scenarios plus random traffic, every cycle checked
// against a duration-counting model of the note player.
module tb_note_sequencer;

   localparam int DEPTH = 8;
   localparam int CPM   = 4;
   localparam int GAP   = 2;
   localparam int HN    = 8192;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        stop = 1'b0;
   logic        wr_valid = 1'b0;
   logic [31:0] wr_div = '0;
   logic [3:0]  wr_vol = '0;
   logic [15:0] wr_dur_ms = '0;
   logic        wr_ready;
   logic [31:0] clks_per_period;
   logic [3:0]  volume;
   logic        new_period, mute, busy, note_done;
   logic [3:0]  fifo_count;

   note_sequencer #(.DEPTH(DEPTH), .CLKS_PER_MS(CPM), .GAP_MS(GAP)) dut (
      .clk(clk), .reset(reset), .enable(enable), .stop(stop),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_div(wr_div), .wr_vol(wr_vol),
      .wr_dur_ms(wr_dur_ms), .clks_per_period(clks_per_period), .volume(volume),
      .new_period(new_period), .mute(mute), .busy(busy), .note_done(note_done),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cycle = 0;
   int done_cnt = 0;
   int np_cnt = 0;
   bit checking = 0;

   typedef struct packed {
      logic [31:0] div;
      logic [3:0]  vol;
      logic [15:0] dur;
   } note_t;

   // model: notes are a push/pop history log; playback is tracked as cycles left
   typedef struct packed {
      int          play;   // tone/rest cycles still to run, including the current one
      int          gap;    // muted gap cycles still to run
      int          push;   // notes accepted so far
      int          pop;    // notes consumed so far
      logic        load;   // this cycle consumes the head note
      logic        rest;
      logic        np;
      logic [31:0] cpp;
      logic [3:0]  vol;
   } model_t;

   note_t  hist [HN];
   model_t m = '0;

   function automatic model_t model_next(input model_t c, input logic rst, input logic st,
                                         input logic en, input logic wv);
      model_t n;
      note_t  e;
      int     size;
      n    = c;
      n.np = 1'b0;
      size = c.push - c.pop;
      if (rst) begin
         n = '0;
      end else if (st) begin
         n.play = 0;
         n.gap  = 0;
         n.load = 1'b0;
         n.pop  = c.push;
      end else begin
         if (c.load) begin
            e      = hist[c.pop % HN];
            n.pop  = c.pop + 1;
            n.load = 1'b0;
            if (e.dur != 16'd0) begin
               n.play = int'(e.dur) * CPM;
               n.rest = (e.div == 32'd0);
               if (e.div != 32'd0) begin
                  n.cpp = e.div;
                  n.vol = e.vol;
                  n.np  = 1'b1;
               end
            end
         end else if (c.play > 0) begin
            n.play = c.play - 1;
            if (n.play == 0) begin
               if (GAP > 0) n.gap = GAP * CPM;
               else         n.load = en && (size > 0);
            end
         end else if (c.gap > 0) begin
            n.gap = c.gap - 1;
            if (n.gap == 0) n.load = en && (size > 0);
         end else begin
            n.load = en && (size > 0);
         end
         if (wv && (size < DEPTH)) n.push = c.push + 1;
      end
      return n;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cycle, act, exp);
      end
   endtask

   // model advance and history capture at each active edge
   always @(posedge clk) begin
      m <= model_next(m, reset, stop, enable, wr_valid);
      if (!reset && !stop && wr_valid && ((m.push - m.pop) < DEPTH))
         hist[m.push % HN] <= {wr_div, wr_vol, wr_dur_ms};
      cycle <= cycle + 1;
      if (note_done === 1'b1) done_cnt <= done_cnt + 1;
      if (new_period === 1'b1) np_cnt <= np_cnt + 1;
   end

   // per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (checking) begin
         chk("clks_per_period", clks_per_period, m.cpp);
         chk("volume", 32'(volume), 32'(m.vol));
         chk("new_period", 32'(new_period), 32'(m.np));
         chk("mute", 32'(mute), 32'(!((m.play > 0) && !m.rest)));
         chk("busy", 32'(busy), 32'(m.load || (m.play > 0) || (m.gap > 0)));
         chk("note_done", 32'(note_done), 32'(m.play == 1));
         chk("fifo_count", 32'(fifo_count), 32'(m.push - m.pop));
         chk("wr_ready", 32'(wr_ready), 32'((m.push - m.pop) < DEPTH));
      end
   end

   task automatic push(input logic [31:0] d, input logic [3:0] v, input logic [15:0] du);
      wr_valid  = 1'b1;
      wr_div    = d;
      wr_vol    = v;
      wr_dur_ms = du;
      @(negedge clk);
      wr_valid  = 1'b0;
   endtask

   task automatic wait_np(input int limit, output int t);
      bit seen;
      seen = 0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         if (new_period === 1'b1) seen = 1;
      end
      t = cycle;
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_new_period: no strobe within %0d cycles", limit);
      end
   endtask

   task automatic wait_level(input string nm, input int limit, input bit want_done);
      bit seen;
      seen = 0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         if (want_done ? (note_done === 1'b1) : (busy === 1'b0)) seen = 1;
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: condition not reached within %0d cycles", nm, limit);
      end
   endtask

   initial begin
      int t1, t2, d0, n0;
      repeat (2) @(negedge clk);
      checking = 1;
      chk("reset_mute", 32'(mute), 32'd1);
      chk("reset_ready", 32'(wr_ready), 32'd1);
      chk("reset_count", 32'(fifo_count), 32'd0);
      reset  = 1'b0;
      enable = 1'b1;
      @(negedge clk);

      // reset while a note is sounding
      push(32'd100, 4'd15, 16'd3);
      @(negedge clk);
      @(negedge clk);
      chk("first_strobe", 32'(new_period), 32'd1);
      chk("first_cpp", clks_per_period, 32'd100);
      chk("first_vol", 32'(volume), 32'd15);
      chk("first_mute", 32'(mute), 32'd0);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midplay_reset_cpp", clks_per_period, 32'd0);
      chk("midplay_reset_vol", 32'(volume), 32'd0);
      chk("midplay_reset_mute", 32'(mute), 32'd1);
      chk("midplay_reset_busy", 32'(busy), 32'd0);

      // note, gap, note spacing
      push(32'd50, 4'd7, 16'd2);
      push(32'd80, 4'd3, 16'd1);
      wait_np(10, t1);
      wait_np(40, t2);
      chk("strobe_spacing", 32'(t2 - t1), 32'd17);
      chk("second_cpp", clks_per_period, 32'd80);
      repeat (11) @(negedge clk);
      chk("busy_in_last_gap", 32'(busy), 32'd1);
      @(negedge clk);
      chk("idle_after_gap", 32'(busy), 32'd0);

      // rest, discarded zero-length entry, then a tone
      d0 = done_cnt;
      n0 = np_cnt;
      push(32'd0, 4'd5, 16'd2);
      push(32'd123, 4'd9, 16'd0);
      push(32'd60, 4'd4, 16'd1);
      wait_np(60, t1);
      chk("after_rest_cpp", clks_per_period, 32'd60);
      chk("rest_done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("rest_no_strobe", 32'(np_cnt - n0), 32'd0);
      wait_level("idle_after_rest", 60, 0);

      // overfill with playback held off, then drain in order
      enable = 1'b0;
      for (int i = 0; i < 9; i++) push(32'(200 + i), 4'(i), 16'd1);
      chk("full_count", 32'(fifo_count), 32'd8);
      chk("full_ready", 32'(wr_ready), 32'd0);
      enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wait_np(40, t1);
         chk("drain_order", clks_per_period, 32'(200 + i));
      end
      wait_level("idle_after_drain", 60, 0);

      // stop during the gap with notes still queued
      for (int i = 0; i < 4; i++) push(32'(300 + i), 4'd1, 16'd1);
      wait_level("first_done", 30, 1);
      @(negedge clk);
      chk("count_in_gap", 32'(fifo_count), 32'd3);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("stop_count", 32'(fifo_count), 32'd0);
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_mute", 32'(mute), 32'd1);
      n0 = np_cnt;
      repeat (20) @(negedge clk);
      chk("stop_no_strobe", 32'(np_cnt - n0), 32'd0);
      push(32'd77, 4'd2, 16'd1);
      wait_np(10, t1);
      chk("after_stop_cpp", clks_per_period, 32'd77);
      wait_level("idle_after_stop", 40, 0);

      // enable dropped mid-note keeps the queue, re-enable strobes two cycles later
      push(32'd31, 4'd1, 16'd1);
      push(32'd32, 4'd2, 16'd1);
      wait_np(10, t1);
      enable = 1'b0;
      wait_level("idle_after_disable", 40, 0);
      chk("retained_count", 32'(fifo_count), 32'd1);
      enable = 1'b1;
      @(negedge clk);
      chk("reenable_load", 32'(new_period), 32'd0);
      @(negedge clk);
      chk("reenable_strobe", 32'(new_period), 32'd1);
      chk("reenable_cpp", clks_per_period, 32'd32);

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         reset    = ($urandom_range(0, 499) == 0);
         stop     = ($urandom_range(0, 199) == 0);
         if (!enable && ($urandom_range(0, 9) == 0)) enable = 1'b1;
         else if (enable && ($urandom_range(0, 49) == 0)) enable = 1'b0;
         wr_valid  = ($urandom_range(0, 9) < 3);
         wr_div    = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
         wr_vol    = 4'($urandom_range(0, 15));
         wr_dur_ms = 16'($urandom_range(0, 2));
      end
      @(negedge clk);
      reset    = 1'b0;
      stop     = 1'b0;
      wr_valid = 1'b0;
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
